// File: rtl/packet_mux.sv
// packet_mux: wormhole N:1 packet multiplexer, round-robin HEAD arbitration, registered output.
// Optional macro PACKET_MUX_STATS_EN adds flit_cnt/pkt_cnt transfer counters.
module packet_mux #(
    parameter int NPORT = 4,
    parameter int DATAW = 66,
    parameter int VCHW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT*DATAW-1:0] idata,
    input  logic [NPORT-1:0]       ivalid,
    input  logic [NPORT*VCHW-1:0]  ivch,
    output logic [NPORT-1:0]       iready,
    output logic [DATAW-1:0]       odata,
    output logic                   ovalid,
    output logic [VCHW-1:0]        ovch,
    input  logic                   oready,
    output logic [NPORT-1:0]       grant
`ifdef PACKET_MUX_STATS_EN
    ,
    output logic [31:0]            flit_cnt,
    output logic [15:0]            pkt_cnt
`endif
);
    localparam int PW = $clog2(NPORT);
    localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10;
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_n;
    logic [PW-1:0] rr_ptr, gidx, pick, port;
    logic pick_ok, free, take;
    logic [NPORT-1:0] cand;
    logic [DATAW-1:0] flit;
    logic [1:0] ftype;
    always_comb begin
        cand = '0;
        for (int k = 0; k < NPORT; k++)
            cand[k] = ivalid[k] && idata[k*DATAW+DATAW-2 +: 2] == T_HEAD;
    end
    // scan downward so the candidate nearest rr_ptr is the last, winning assignment
    always_comb begin
        pick = '0;
        pick_ok = 1'b0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (cand[(int'(rr_ptr) + i) % NPORT]) begin
                pick = PW'((int'(rr_ptr) + i) % NPORT);
                pick_ok = 1'b1;
            end
        end
    end
    assign free   = !ovalid || oready;
    assign port   = state == LOCKED ? gidx : pick;
    assign flit   = idata[port*DATAW +: DATAW];
    assign ftype  = flit[DATAW-1 -: 2];
    assign take   = !rst && free && (state == LOCKED ? ivalid[port] && ftype != T_NONE : pick_ok);
    assign iready = take ? NPORT'(1) << port : '0;
    assign grant  = state == LOCKED ? NPORT'(1) << gidx : '0;
    always_comb begin
        state_n = state;
        if (take)
            state_n = state == IDLE ? LOCKED : (ftype == T_TAIL ? IDLE : LOCKED);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gidx   <= '0;
            ovalid <= 1'b0;
            odata  <= '0;
            ovch   <= '0;
        end else begin
            state <= state_n;
            if (take && state == IDLE)
                gidx <= pick;
            if (take && state == LOCKED && ftype == T_TAIL)
                rr_ptr <= gidx == PW'(NPORT - 1) ? '0 : gidx + 1'b1;
            if (take) begin
                odata  <= flit;
                ovch   <= ivch[port*VCHW +: VCHW];
                ovalid <= 1'b1;
            end else if (oready) begin
                ovalid <= 1'b0;
            end
        end
    end
`ifdef PACKET_MUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (ovalid && oready) begin
            flit_cnt <= flit_cnt + 1'b1;
            if (odata[DATAW-1 -: 2] == T_TAIL)
                pkt_cnt <= pkt_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_packet_mux.sv
// tb_packet_mux: table-driven arbitration vectors plus scoreboarded packet sequences for packet_mux.
module tb_packet_mux;
    localparam int NPORT = 4;
    localparam int DATAW = 66;
    localparam logic [1:0] NONE = 2'b00, HEAD = 2'b01, TAIL = 2'b10, DATA = 2'b11;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NPORT*DATAW-1:0] idata = '0;
    logic [NPORT-1:0] ivalid = '0;
    logic [NPORT*2-1:0] ivch = 8'he4;
    logic [NPORT-1:0] iready;
    logic [DATAW-1:0] odata;
    logic ovalid;
    logic [1:0] ovch;
    logic oready = 1'b1;
    logic [NPORT-1:0] grant;
`ifdef PACKET_MUX_STATS_EN
    logic [31:0] flit_cnt;
    logic [15:0] pkt_cnt;
`endif
    packet_mux #(.NPORT(NPORT), .DATAW(DATAW), .VCHW(2)) dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready),
        .odata(odata), .ovalid(ovalid), .ovch(ovch), .oready(oready), .grant(grant)
`ifdef PACKET_MUX_STATS_EN
        , .flit_cnt(flit_cnt), .pkt_cnt(pkt_cnt)
`endif
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {logic [DATAW-1:0] d; logic [1:0] v; int c;} ent_t;
    ent_t sb[$];
    logic [DATAW-1:0] pq[NPORT][$];
    int total = 0, bad = 0;
    bit strict = 0;
    function automatic logic [DATAW-1:0] mk(input logic [1:0] t, input int p, input int s);
        return {t, 32'(p), 32'(s)};
    endfunction
    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask
    task automatic load(input int p, input int nd, input int tag);
        pq[p].push_back(mk(HEAD, p, tag * 100));
        for (int i = 1; i <= nd; i++) pq[p].push_back(mk(DATA, p, tag * 100 + i));
        pq[p].push_back(mk(TAIL, p, tag * 100 + nd + 1));
    endtask
    function automatic int pending();
        int n = 0;
        for (int k = 0; k < NPORT; k++) n += pq[k].size();
        return n;
    endfunction
    task automatic apply();
        for (int k = 0; k < NPORT; k++) begin
            ivalid[k] = pq[k].size() != 0;
            idata[k*DATAW +: DATAW] = ivalid[k] ? pq[k][0] : '0;
        end
        #1;
    endtask
    task automatic clk_step();
        logic x;
        logic [DATAW-1:0] d;
        logic [1:0] v;
        logic [NPORT-1:0] acc;
        int cy0;
        ent_t e;
        x = ovalid && oready && !rst;
        d = odata;
        v = ovch;
        cy0 = cyc;
        acc = rst ? '0 : (ivalid & iready);
        for (int k = 0; k < NPORT; k++)
            if (acc[k]) sb.push_back('{idata[k*DATAW +: DATAW], 2'(k), cy0});
        @(posedge clk);
        for (int k = 0; k < NPORT; k++)
            if (acc[k]) void'(pq[k].pop_front());
        if (x) begin
            chk("out_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("odata", d, e.d);
                chk("ovch", v, e.v);
                if (strict) chk("latency", cy0 - e.c, 1);
            end
        end
        #1;
    endtask
    task automatic tick();
        apply();
        clk_step();
    endtask
    task automatic run(input int lim);
        int n = 0;
        while (pending() != 0 && n < lim) begin
            tick();
            n++;
        end
        chk("run_in_budget", n < lim, 1);
        tick();
        tick();
        chk("sb_drained", sb.size(), 0);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        apply();
        clk_step();
        sb.delete();
        rst = 1'b0;
    endtask
    typedef struct {logic [3:0] v; logic [7:0] t; logic [3:0] exp;} vec_t;
    vec_t tbl[7];
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int n, idx;
        logic [DATAW-1:0] held;
        tbl[0] = '{4'b0001, 8'b01_01_01_01, 4'b0001};
        tbl[1] = '{4'b1010, 8'b01_01_01_01, 4'b0010};
        tbl[2] = '{4'b1111, 8'b01_01_10_11, 4'b0100};
        tbl[3] = '{4'b0000, 8'b01_01_01_01, 4'b0000};
        tbl[4] = '{4'b1000, 8'b00_01_01_01, 4'b0000};
        tbl[5] = '{4'b1100, 8'b01_11_00_00, 4'b1000};
        tbl[6] = '{4'b1111, 8'b11_11_11_11, 4'b0000};
        repeat (2) @(posedge clk);
        #1;
        ivalid = 4'hF;
        for (int k = 0; k < NPORT; k++) idata[k*DATAW +: DATAW] = mk(HEAD, k, 0);
        #1;
        chk("rst_iready", iready, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_odata", odata, 0);
        chk("rst_ovch", ovch, 0);
        for (int i = 0; i < 7; i++) begin
            rst = 1'b1;
            ivalid = '0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            ivalid = tbl[i].v;
            idx = 0;
            for (int k = 0; k < NPORT; k++) begin
                idata[k*DATAW +: DATAW] = mk(tbl[i].t[k*2 +: 2], k, i);
                if (tbl[i].exp[k]) idx = k;
            end
            #1;
            chk($sformatf("tbl%0d_iready", i), iready, tbl[i].exp);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].exp);
            chk($sformatf("tbl%0d_ovalid", i), ovalid, |tbl[i].exp);
            if (tbl[i].exp != 0) chk($sformatf("tbl%0d_odata", i), odata, mk(HEAD, idx, i));
        end
        do_reset();
        load(1, 20, 1);
        strict = 1;
        tick();
        for (int i = 0; i < 21; i++) begin
            apply();
            chk("single_grant", grant, 4'b0010);
            clk_step();
        end
        apply();
        chk("single_idle", grant, 0);
        clk_step();
        run(10);
        strict = 0;
        do_reset();
        load(0, 3, 2);
        load(2, 2, 3);
        apply();
        chk("cont_iready", iready, 4'b0001);
        clk_step();
        apply();
        chk("cont_grant0", grant, 4'b0001);
        clk_step();
        n = 0;
        while (pq[0].size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("cont_p0_done", n < 20, 1);
        apply();
        chk("gap_grant", grant, 0);
        chk("gap_iready", iready, 4'b0100);
        clk_step();
        apply();
        chk("cont_grant2", grant, 4'b0100);
        clk_step();
        run(50);
        load(0, 1, 4);
        load(3, 1, 5);
        apply();
        chk("rr3_iready", iready, 4'b1000);
        clk_step();
        run(50);
        load(1, 8, 6);
        repeat (4) tick();
        oready = 1'b0;
        held = odata;
        for (int i = 0; i < 5; i++) begin
            apply();
            chk("bp_iready", iready, 0);
            chk("bp_hold", odata, held);
            chk("bp_ovalid", ovalid, 1);
            clk_step();
        end
        oready = 1'b1;
        run(50);
        chk("ovalid_clear", ovalid, 0);
        pq[3].push_back(mk(DATA, 3, 700));
        apply();
        chk("stray_iready", iready, 0);
        clk_step();
        apply();
        chk("stray_no_out", ovalid, 0);
        clk_step();
        pq[3].delete();
        load(1, 15, 8);
        repeat (7) tick();
        rst = 1'b1;
        apply();
        chk("midrst_iready", iready, 0);
        clk_step();
        sb.delete();
        pq[1].delete();
        rst = 1'b0;
        chk("midrst_ovalid", ovalid, 0);
        chk("midrst_grant", grant, 0);
        load(2, 2, 9);
        apply();
        chk("fresh_iready", iready, 4'b0100);
        clk_step();
        apply();
        chk("fresh_grant", grant, 4'b0100);
        clk_step();
        run(50);
`ifdef PACKET_MUX_STATS_EN
        do_reset();
        for (int p = 0; p < 10; p++) load(p % NPORT, 20, 20 + p);
        run(2000);
        chk("flit_cnt", flit_cnt, 220);
        chk("pkt_cnt", pkt_cnt, 10);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
